// File: rtl/base_endian_arb.sv
// ============================================================================
// Module   : base_endian_arb
// Summary  : Two-requester round-robin arbiter feeding a byte-reversal mux and
//            a valid/ready output stage tagged with the source requester.
//            Optional feature macro: BASE_ENDIAN_ARB_SKID_EN (2-entry FIFO).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module base_endian_arb #(
  parameter int BYTES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i0_v,
  output logic               i0_r,
  input  logic [8*BYTES-1:0] i0_d,
  input  logic               i0_swap,
  input  logic               i1_v,
  output logic               i1_r,
  input  logic [8*BYTES-1:0] i1_d,
  input  logic               i1_swap,
  output logic               o_v,
  input  logic               o_r,
  output logic [8*BYTES-1:0] o_d,
  output logic               o_tag,
  output logic               o_swap
);

  localparam int W  = 8 * BYTES;
  localparam int BW = W + 2;

  logic          lst_q;
  logic          lst_d;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_can_acc;
  logic          w_acc;
  logic [W-1:0]  w_sel_d;
  logic          w_sel_swap;
  logic [W-1:0]  w_rev_d;
  logic [W-1:0]  w_proc_d;
  logic [BW-1:0] w_beat;

  // Tie goes to whichever requester was not served last.
  assign w_grant0 = i0_v & (~i1_v | lst_q);
  assign w_grant1 = i1_v & (~i0_v | ~lst_q);

  assign i0_r  = w_grant0 & w_can_acc & ~reset;
  assign i1_r  = w_grant1 & w_can_acc & ~reset;
  assign w_acc = i0_r | i1_r;

  assign w_sel_d    = i1_r ? i1_d    : i0_d;
  assign w_sel_swap = i1_r ? i1_swap : i0_swap;

  for (genvar k = 0; k < BYTES; k++) begin : g_swap
    assign w_rev_d[8*k +: 8] = w_sel_d[8*(BYTES-1-k) +: 8];
  end

  assign w_proc_d = w_sel_swap ? w_rev_d : w_sel_d;
  assign w_beat   = {i1_r, w_sel_swap, w_proc_d};
  assign lst_d    = w_acc ? i1_r : lst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lst_q <= 1'b1;
    end else begin
      lst_q <= lst_d;
    end
  end

`ifdef BASE_ENDIAN_ARB_SKID_EN

  logic [BW-1:0] mem_q [2];
  logic          rd_q;
  logic          wr_q;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic          w_pop;

  // Capacity depends only on the registered count, so o_r never reaches iN_r.
  assign w_can_acc = (cnt_q != 2'd2);
  assign w_pop     = (cnt_q != 2'd0) & o_r;

  always_comb begin
    cnt_d = cnt_q;
    if (w_acc && !w_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!w_acc && w_pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_acc) begin
        mem_q[wr_q] <= w_beat;
        wr_q        <= ~wr_q;
      end
      if (w_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign o_v                  = (cnt_q != 2'd0);
  assign {o_tag, o_swap, o_d} = mem_q[rd_q];

`else

  logic          ov_q;
  logic [BW-1:0] ob_q;

  assign w_can_acc = ~ov_q | o_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q <= 1'b0;
      ob_q <= '0;
    end else if (w_acc) begin
      ov_q <= 1'b1;
      ob_q <= w_beat;
    end else if (o_r) begin
      ov_q <= 1'b0;
    end
  end

  assign o_v                  = ov_q;
  assign {o_tag, o_swap, o_d} = ob_q;

`endif

endmodule

`default_nettype wire

// File: tb/tb_base_endian_arb.sv
// ============================================================================
// Module   : tb_base_endian_arb
// Summary  : Randomized scoreboard bench for base_endian_arb (BYTES=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_base_endian_arb;

  localparam int BYTES = 8;
  localparam int W     = 8 * BYTES;
`ifdef BASE_ENDIAN_ARB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk;
  logic         reset;
  logic         i0_v, i0_r, i0_swap;
  logic         i1_v, i1_r, i1_swap;
  logic [W-1:0] i0_d, i1_d;
  logic         o_v, o_r, o_tag, o_swap;
  logic [W-1:0] o_d;

  base_endian_arb #(.BYTES(BYTES)) dut (
    .clk     (clk),
    .reset   (reset),
    .i0_v    (i0_v),
    .i0_r    (i0_r),
    .i0_d    (i0_d),
    .i0_swap (i0_swap),
    .i1_v    (i1_v),
    .i1_r    (i1_r),
    .i1_d    (i1_d),
    .i1_swap (i1_swap),
    .o_v     (o_v),
    .o_r     (o_r),
    .o_d     (o_d),
    .o_tag   (o_tag),
    .o_swap  (o_swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [W+1:0] beat_t;
  beat_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc0 = 0;
  int n_acc1 = 0;
  int occ    = 0;
  logic lst_m = 1'b1;

  task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev_bytes(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < BYTES; k++) r = {r[W-9:0], d[8*k +: 8]};
    return r;
  endfunction

  // One clock of stimulus; readies are checked against the arbitration rules.
  task automatic step(input logic rs, input logic v0, input logic s0, input logic [W-1:0] d0,
                      input logic v1, input logic s1, input logic [W-1:0] d1, input logic orr);
    logic e0, e1, cap, pop;
    @(posedge clk);
    #1;
    reset = rs; i0_v = v0; i0_swap = s0; i0_d = d0;
    i1_v = v1; i1_swap = s1; i1_d = d1; o_r = orr;
    @(negedge clk);
    cap = (DEPTH == 2) ? (occ != 2) : (occ == 0 || orr);
    e0  = v0 && (!v1 || lst_m) && cap && !rs;
    e1  = v1 && (!v0 || !lst_m) && cap && !rs;
    chk("i0_r", {65'd0, i0_r}, {65'd0, e0});
    chk("i1_r", {65'd0, i1_r}, {65'd0, e1});
    if (!rs) chk("o_v", {65'd0, o_v}, {65'd0, occ != 0});
    if (i0_r && i1_r) chk("ready_onehot", 66'd1, 66'd0);
    if (i0_r) n_acc0++;
    if (i1_r) n_acc1++;
    #2;
    if (rs) begin
      occ = 0;
      lst_m = 1'b1;
      exp_q.delete();
    end else begin
      pop = (occ != 0) && orr;
      if (e0) exp_q.push_back({1'b0, s0, s0 ? rev_bytes(d0) : d0});
      if (e1) exp_q.push_back({1'b1, s1, s1 ? rev_bytes(d1) : d1});
      if (e0 || e1) lst_m = e1;
      occ = occ + ((e0 || e1) ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  task automatic idle(input logic orr);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, orr);
  endtask

  function automatic logic [W-1:0] rnd_d();
    return {$urandom, $urandom};
  endfunction

  // Output monitor: pops the scoreboard on every downstream transfer.
  logic  held;
  beat_t held_val;
  initial begin
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) chk("hold", {o_tag, o_swap, o_d}, held_val);
        if (o_v && o_r) begin
          if (exp_q.size() == 0) chk("spurious_out", {o_tag, o_swap, o_d}, '1 ^ {o_tag, o_swap, o_d});
          else chk("scoreboard", {o_tag, o_swap, o_d}, exp_q.pop_front());
        end
        held = o_v && !o_r;
        held_val = {o_tag, o_swap, o_d};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int a0, a1;
    logic [3:0] gseq;
    reset = 1'b1; i0_v = 0; i1_v = 0; i0_swap = 0; i1_swap = 0;
    i0_d = '0; i1_d = '0; o_r = 0;

    // Reset, with requesters valid to show readies stay low.
    step(1'b1, 1'b1, 1'b0, 64'h1, 1'b1, 1'b0, 64'h2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 64'h1, 1'b1, 1'b0, 64'h2, 1'b1);
    idle(1'b0);
    chk("rst_o_d", {2'b0, o_d}, '0);
    chk("rst_o_tag", {65'd0, o_tag}, 66'd0);
    chk("rst_o_swap", {65'd0, o_swap}, 66'd0);

    // Swap rule.
    step(1'b0, 1'b1, 1'b1, 64'h0011223344556677, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 64'h0011223344556677, 1'b0, 1'b0, '0, 1'b1);
    chk("swap1_d", {o_tag, o_swap, o_d}, {2'b01, 64'h7766554433221100});
    idle(1'b1);
    chk("swap0_d", {o_tag, o_swap, o_d}, {2'b00, 64'h0011223344556677});
    idle(1'b1);

    // Tie after reset alternates 0,1,0,1.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b1, 1'b1, rnd_d(), 1'b1);
      gseq[i] = i1_r;
    end
    chk("tie_seq", {62'd0, gseq}, 66'b1010);
    idle(1'b1);

    // Backpressure: stage fills to its depth, then stalls.
    a0 = n_acc0; a1 = n_acc1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, rnd_d(), 1'b1, 1'b0, rnd_d(), 1'b0);
    chk("bp_accepts", 66'(n_acc0 + n_acc1 - a0 - a1), 66'(DEPTH));
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("bp_drain", 66'(exp_q.size()), 66'd0);

    // Single requester streams back-to-back.
    a0 = n_acc0; a1 = n_acc1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, i[0], 64'h1000 + 64'(i), 1'b1);
    chk("single_acc1", 66'(n_acc1 - a1), 66'd4);
    chk("single_acc0", 66'(n_acc0 - a0), 66'd0);
    idle(1'b1);

    // Reset mid-stream discards the buffered beat.
    step(1'b0, 1'b1, 1'b1, 64'hdeadbeefcafef00d, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("pre_rst_o_v", {65'd0, o_v}, 66'd1);
    idle(1'b0);
    chk("mid_rst_o_d", {o_tag, o_swap, o_d}, '0);
    step(1'b0, 1'b1, 1'b0, rnd_d(), 1'b1, 1'b0, rnd_d(), 1'b1);
    chk("post_rst_tie", {65'd0, i0_r}, 66'd1);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), rnd_d(), 1'($urandom), 1'($urandom), rnd_d(),
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_drain", 66'(exp_q.size()), 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
